memmux_swap_ctrl: RTL and testbench

MEMMUX_SWAP_CTRL -- requirements
Module: memmux_swap_ctrl

---
 rtl/memmux_swap_ctrl.sv | 155 +++++++++++++++
 tb/tb_memmux_swap_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/memmux_swap_ctrl.sv
// Video scan-address generator and double-buffer bank swap controller for a memory mux.
// Bank swaps requested by the writer are committed only at the SCAN->BLANK boundary.
module memmux_swap_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256,
    parameter int BLANK_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  swap_pending,
    output logic                  switch,
    output logic [ADDR_WIDTH-1:0] vaddr,
    output logic                  frame_start
);

    localparam logic SCAN  = 1'b0;
    localparam logic BLANK = 1'b1;

    localparam logic [1:0] H_IDLE = 2'd0;
    localparam logic [1:0] H_PEND = 2'd1;
    localparam logic [1:0] H_DONE = 2'd2;

    // Comparing against the last legal address keeps vaddr bounded even when FRAME_LEN fills the address space.
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [15:0]           BLANK_LAST = 16'(BLANK_LEN - 1);

    logic                  scanState;
    logic                  scanNext;
    logic [ADDR_WIDTH-1:0] vaddrReg;
    logic [ADDR_WIDTH-1:0] vaddrNext;
    logic [15:0]           blankCnt;
    logic [15:0]           blankNext;
    logic                  switchReg;
    logic                  switchNext;
    logic [1:0]            hState;
    logic [1:0]            hNext;
    logic                  swapAckReg;
    logic                  swapFire;
    logic                  frameStartReg;
    logic                  frameStartNext;
    logic                  pendingReg;

    // Scan/blank sequencing and the frame-end swap decision.
    always_comb begin
        scanNext       = scanState;
        vaddrNext      = vaddrReg;
        blankNext      = blankCnt;
        switchNext     = switchReg;
        swapFire       = 1'b0;
        frameStartNext = 1'b0;
        if (enable) begin
            case (scanState)
                SCAN: begin
                    if (vaddrReg == LAST_ADDR) begin
                        scanNext  = BLANK;
                        blankNext = 16'd0;
                        vaddrNext = ADDR_ZERO;
                        if (hState == H_PEND) begin
                            swapFire   = 1'b1;
                            switchNext = ~switchReg;
                        end else begin
                            swapFire   = 1'b0;
                            switchNext = switchReg;
                        end
                    end else begin
                        vaddrNext = vaddrReg + ADDR_ONE;
                    end
                end
                BLANK: begin
                    vaddrNext = ADDR_ZERO;
                    if (blankCnt == BLANK_LAST) begin
                        scanNext       = SCAN;
                        blankNext      = 16'd0;
                        frameStartNext = 1'b1;
                    end else begin
                        blankNext = blankCnt + 16'd1;
                    end
                end
                default: begin
                    scanNext  = SCAN;
                    vaddrNext = ADDR_ZERO;
                    blankNext = 16'd0;
                end
            endcase
        end else begin
            scanNext  = scanState;
            vaddrNext = vaddrReg;
            blankNext = blankCnt;
        end
    end

    // Writer handshake: latch a request, retire it on the swap, then wait for the request to drop.
    always_comb begin
        hNext = hState;
        case (hState)
            H_IDLE: begin
                if (swap_req) begin
                    hNext = H_PEND;
                end else begin
                    hNext = H_IDLE;
                end
            end
            H_PEND: begin
                if (swapFire) begin
                    hNext = H_DONE;
                end else begin
                    hNext = H_PEND;
                end
            end
            H_DONE: begin
                if (!swap_req) begin
                    hNext = H_IDLE;
                end else begin
                    hNext = H_DONE;
                end
            end
            default: hNext = H_IDLE;
        endcase
    end

    // State and output registers; reset discards any latched request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scanState     <= SCAN;
            vaddrReg      <= ADDR_ZERO;
            blankCnt      <= 16'd0;
            switchReg     <= 1'b0;
            hState        <= H_IDLE;
            swapAckReg    <= 1'b0;
            frameStartReg <= 1'b0;
            pendingReg    <= 1'b0;
        end else begin
            scanState     <= scanNext;
            vaddrReg      <= vaddrNext;
            blankCnt      <= blankNext;
            switchReg     <= switchNext;
            hState        <= hNext;
            swapAckReg    <= swapFire;
            frameStartReg <= frameStartNext;
            pendingReg    <= (hNext == H_PEND);
        end
    end

    assign vaddr        = vaddrReg;
    assign switch       = switchReg;
    assign swap_ack     = swapAckReg;
    assign frame_start  = frameStartReg;
    assign swap_pending = pendingReg;

endmodule

// File: tb/tb_memmux_swap_ctrl.sv
// Directed bench for memmux_swap_ctrl with FRAME_LEN=4 filling a 2-bit address space, BLANK_LEN=2.
module tb_memmux_swap_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       swap_req;
    logic       swapAck;
    logic       swapPending;
    logic       sw;
    logic [1:0] vaddr;
    logic       frameStart;

    int nCompared;
    int nMismatch;

    memmux_swap_ctrl #(
        .ADDR_WIDTH(2),
        .FRAME_LEN (4),
        .BLANK_LEN (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .swap_req    (swap_req),
        .swap_ack    (swapAck),
        .swap_pending(swapPending),
        .switch      (sw),
        .vaddr       (vaddr),
        .frame_start (frameStart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectAll(input string tag, input logic [1:0] v, input logic s,
                             input logic ack, input logic pend, input logic fs);
        checkVal({tag, ".vaddr"}, 32'(vaddr), 32'(v));
        checkVal({tag, ".switch"}, 32'(sw), 32'(s));
        checkVal({tag, ".ack"}, 32'(swapAck), 32'(ack));
        checkVal({tag, ".pending"}, 32'(swapPending), 32'(pend));
        checkVal({tag, ".fstart"}, 32'(frameStart), 32'(fs));
    endtask

    logic [1:0] seqV  [7];
    logic       seqFs [7];

    initial begin
        nCompared = 0;
        nMismatch = 0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        swap_req  = 1'b1;
        tick();
        tick();
        expectAll("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n    = 1'b1;
        swap_req = 1'b0;

        // Plain frame after reset: 1,2,3 then two blanking zeros, first scan zero with frame_start.
        seqV  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
        seqFs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            tick();
            expectAll($sformatf("frame0[%0d]", i), seqV[i], 1'b0, 1'b0, 1'b0, seqFs[i]);
        end

        // Request at vaddr=1, held until ack.
        swap_req = 1'b1;
        tick(); expectAll("req.v2", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); expectAll("req.v3", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); expectAll("req.swap", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        swap_req = 1'b0;
        tick(); expectAll("req.blank2", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expectAll("req.fs", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick(); expectAll("late.v3", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // Request raised in the last scan cycle, then dropped while pending.
        swap_req = 1'b1;
        tick(); expectAll("late.noswap", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        swap_req = 1'b0;
        tick(); expectAll("late.blank2", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); expectAll("late.fs", 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        tick(); expectAll("late.v3b", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); expectAll("late.swap", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick(); expectAll("late.fs2", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Held request across three frames after ack swaps exactly once.
        swap_req = 1'b1;
        tick(); expectAll("hold.v1", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        tick(); expectAll("hold.swap", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            tick();
            checkVal($sformatf("hold.sw[%0d]", i), 32'(sw), 32'd1);
            checkVal($sformatf("hold.ack[%0d]", i), 32'(swapAck), 32'd0);
        end
        swap_req = 1'b0;
        tick(); expectAll("hold.release", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        swap_req = 1'b1;
        tick(); expectAll("hold.rereq", 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        tick(); expectAll("hold.v3", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); expectAll("hold.swapback", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        swap_req = 1'b0;
        tick();
        tick(); expectAll("hold.fs", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); expectAll("stall.pre", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Enable low for five cycles at vaddr=2.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expectAll($sformatf("stall[%0d]", i), 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        enable = 1'b1;
        tick(); expectAll("stall.resume", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick(); expectAll("rst.fs", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset while pending at vaddr=2 discards the request.
        swap_req = 1'b1;
        tick(); expectAll("rst.pend", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        swap_req = 1'b0;
        rst_n    = 1'b0;
        tick(); expectAll("rst.mid", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(); expectAll("rst.v1", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick(); expectAll("rst.v3", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); expectAll("rst.noswap", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick(); expectAll("rst.fs2", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
